// File: rtl/spu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : spu_fetch_pkg
// Brief  : Shared constants, FSM states and fetch-group layout for the SPU fetch queue.
// Rev    : 1.0
// ============================================================================

// Group layout is a macro so the top can rebuild it for any parameter set.
`define SPU_FETCH_GROUP_T(IW, NI, PW) struct packed { logic [(NI)-1:0][(IW)-1:0] instr; logic [(NI)-1:0] slot_vld; logic [(PW)-1:0] pc; }

package spu_fetch_pkg;

    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_ISSUE_W   = 2;
    localparam int DEF_ILB_DEPTH = 256;
    localparam int DEF_QDEPTH    = 4;

    localparam logic [31:0] NOP  = 32'h4020_0000;
    localparam logic [31:0] LNOP = 32'h0020_0000;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FETCH  = 2'd1,
        S_REFILL = 2'd2
    } fetch_state_t;

    typedef `SPU_FETCH_GROUP_T(DEF_INSTR_W, DEF_ISSUE_W, $clog2(DEF_ILB_DEPTH)) fetch_group_t;

endpackage

`default_nettype wire

// File: rtl/fetch_group_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_group_fifo
// Brief  : DEPTH-entry FIFO of packed fetch groups with synchronous flush.
// Rev    : 1.0
// ============================================================================
module fetch_group_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam int              CNT_W    = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign count     = r_count;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !w_empty;
    assign rdata     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : spu_fetch_queue
// Brief  : SPU instruction fetch: line buffer -> fetch-group queue -> decode, with redirect padding.
// Rev    : 1.0
// ============================================================================
module spu_fetch_queue
    import spu_fetch_pkg::*;
#(
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int ISSUE_W   = DEF_ISSUE_W,
    parameter int ILB_DEPTH = DEF_ILB_DEPTH,
    parameter int QDEPTH    = DEF_QDEPTH,
    parameter int PC_W      = $clog2(ILB_DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ILB_DEPTH-1:0][INSTR_W-1:0] ins_cache,
    input  logic                              ilb_loaded,
    output logic                              read_enable,
    input  logic                              redirect_vld,
    input  logic [PC_W-1:0]                   redirect_pc,
    output logic                              dec_valid,
    input  logic                              dec_ready,
    output logic [ISSUE_W-1:0][INSTR_W-1:0]   dec_instr,
    output logic [ISSUE_W-1:0]                dec_slot_vld,
    output logic [PC_W-1:0]                   dec_pc,
    output logic [PC_W-1:0]                   fetch_pc
);

    typedef `SPU_FETCH_GROUP_T(INSTR_W, ISSUE_W, PC_W) group_t;

    localparam int               GROUP_W   = $bits(group_t);
    localparam int               CNT_W     = $clog2(QDEPTH+1);
    localparam logic [PC_W-1:0]  LAST_PC   = PC_W'(ILB_DEPTH-ISSUE_W);
    localparam logic [PC_W-1:0]  SLOT_MASK = PC_W'(ISSUE_W-1);
    localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(ISSUE_W);

    fetch_state_t                    r_state;
    fetch_state_t                    w_state_nxt;
    logic [PC_W-1:0]                 r_fetch_pc;
    logic [PC_W-1:0]                 w_fetch_pc_nxt;
    logic [ISSUE_W-1:0]              r_pad;
    logic [ISSUE_W-1:0]              w_pad_nxt;
    logic [ISSUE_W-1:0]              w_redir_pad;
    logic [PC_W-1:0]                 w_redir_off;
    logic                            r_read_enable;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_full;
    logic [CNT_W-1:0]                w_count;
    logic [ISSUE_W-1:0][INSTR_W-1:0] w_slot_instr;
    group_t                          w_wgroup;
    group_t                          w_rgroup;

    assign w_redir_off = redirect_pc & SLOT_MASK;

    // Per-slot assembly: padded slots carry the pipe-matched no-op instead of buffer data.
    for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
        localparam logic [INSTR_W-1:0] PAD_INSTR = (s % 2 == 1) ? INSTR_W'(LNOP) : INSTR_W'(NOP);
        logic [PC_W-1:0] w_idx;
        assign w_idx           = r_fetch_pc | PC_W'(s);
        assign w_slot_instr[s] = r_pad[s] ? PAD_INSTR : ins_cache[w_idx];
        assign w_redir_pad[s]  = (PC_W'(s) < w_redir_off);
    end

    always_comb begin
        w_wgroup          = '0;
        w_wgroup.instr    = w_slot_instr;
        w_wgroup.slot_vld = ~r_pad;
        w_wgroup.pc       = r_fetch_pc;
    end

    assign dec_valid = (w_count != '0);
    assign w_pop     = dec_valid & dec_ready;
    assign w_push    = (r_state == S_FETCH) && !redirect_vld && (!w_full || w_pop);

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pad_nxt      = r_pad;
        if (redirect_vld) begin
            w_fetch_pc_nxt = redirect_pc & ~SLOT_MASK;
            w_pad_nxt      = w_redir_pad;
            // Before the first load the target is parked until the buffer is valid.
            w_state_nxt    = (r_state == S_LOAD && !ilb_loaded) ? S_LOAD : S_FETCH;
        end else begin
            case (r_state)
                S_LOAD, S_REFILL: begin
                    if (ilb_loaded) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_push) begin
                        w_pad_nxt = '0;
                        if (r_fetch_pc == LAST_PC) begin
                            w_fetch_pc_nxt = '0;
                            w_state_nxt    = S_REFILL;
                        end else begin
                            w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
                        end
                    end
                end
                default: w_state_nxt = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_fetch_pc    <= '0;
            r_pad         <= '0;
            r_read_enable <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_pad         <= w_pad_nxt;
            r_read_enable <= (w_state_nxt != S_FETCH);
        end
    end

    fetch_group_fifo #(
        .WIDTH (GROUP_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_vld),
        .wdata (w_wgroup),
        .rdata (w_rgroup),
        .full  (w_full),
        .count (w_count)
    );

    assign read_enable  = r_read_enable;
    assign fetch_pc     = r_fetch_pc;
    assign dec_instr    = dec_valid ? w_rgroup.instr    : '0;
    assign dec_slot_vld = dec_valid ? w_rgroup.slot_vld : '0;
    assign dec_pc       = dec_valid ? w_rgroup.pc       : '0;

endmodule
`default_nettype wire

// File: tb/tb_spu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_spu_fetch_queue
// Brief  : Directed self-checking bench for spu_fetch_queue (ISSUE_W=2, ILB_DEPTH=256, QDEPTH=4).
// Rev    : 1.0
// ============================================================================
module tb_spu_fetch_queue;

    localparam logic [31:0] C_NOP = 32'h4020_0000;

    logic                  clk;
    logic                  reset;
    logic [255:0][31:0]    cache;
    logic                  ilb_loaded;
    logic                  read_enable;
    logic                  redirect_vld;
    logic [7:0]            redirect_pc;
    logic                  dec_valid;
    logic                  dec_ready;
    logic [1:0][31:0]      dec_instr;
    logic [1:0]            dec_slot_vld;
    logic [7:0]            dec_pc;
    logic [7:0]            fetch_pc;

    int n_vec = 0;
    int n_err = 0;

    spu_fetch_queue #(
        .INSTR_W   (32),
        .ISSUE_W   (2),
        .ILB_DEPTH (256),
        .QDEPTH    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ins_cache    (cache),
        .ilb_loaded   (ilb_loaded),
        .read_enable  (read_enable),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_slot_vld (dec_slot_vld),
        .dec_pc       (dec_pc),
        .fetch_pc     (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (read_enable !== 1'b1) begin n_err++; $display("FAIL rst_read_enable: got %b want 1", read_enable); end
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL rst_dec_valid: got %b want 0", dec_valid); end
        n_vec++; if (fetch_pc !== 8'd0) begin n_err++; $display("FAIL rst_fetch_pc: got %0d want 0", fetch_pc); end
        n_vec++; if (dec_slot_vld !== 2'b00 || dec_pc !== 8'd0 || dec_instr !== 64'd0) begin
            n_err++; $display("FAIL rst_dec_outs: got vld=%b pc=%0d instr=%h want 0", dec_slot_vld, dec_pc, dec_instr);
        end
        repeat (3) step();
        n_vec++; if (dec_valid !== 1'b0 || fetch_pc !== 8'd0) begin
            n_err++; $display("FAIL rst_no_fetch: got valid=%b fetch_pc=%0d want 0/0", dec_valid, fetch_pc);
        end
    endtask

    // Redirect while still loading: target is parked, fetch starts there once loaded.
    task automatic test_redirect_in_load();
        redirect_vld = 1'b1; redirect_pc = 8'd7;
        step();
        redirect_vld = 1'b0;
        n_vec++; if (read_enable !== 1'b1 || fetch_pc !== 8'd6) begin
            n_err++; $display("FAIL load_redir_park: got re=%b fetch_pc=%0d want 1/6", read_enable, fetch_pc);
        end
        step(); step();
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL load_redir_nofetch: got %b want 0", dec_valid); end
        ilb_loaded = 1'b1;
        step();
        ilb_loaded = 1'b0;
        n_vec++; if (read_enable !== 1'b0) begin n_err++; $display("FAIL load_redir_re: got %b want 0", read_enable); end
        step();
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'd6 || dec_slot_vld !== 2'b10 ||
                     dec_instr[0] !== C_NOP || dec_instr[1] !== 32'd7) begin
            n_err++; $display("FAIL load_redir_group: got v=%b pc=%0d sv=%b i0=%h i1=%h want 1/6/10/%h/7",
                              dec_valid, dec_pc, dec_slot_vld, dec_instr[0], dec_instr[1], C_NOP);
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        ilb_loaded = 1'b1; dec_ready = 1'b1;
        step();
        ilb_loaded = 1'b0;
        n_vec++; if (read_enable !== 1'b0 || dec_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_start: got re=%b valid=%b want 0/0", read_enable, dec_valid);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'(2*k) || dec_instr[0] !== 32'(2*k) ||
                dec_instr[1] !== 32'(2*k+1) || dec_slot_vld !== 2'b11 || fetch_pc !== 8'(2*k+2)) begin
                n_err++; $display("FAIL stream_grp%0d: got v=%b pc=%0d i0=%0d i1=%0d sv=%b fpc=%0d want 1/%0d/%0d/%0d/11/%0d",
                                  k, dec_valid, dec_pc, dec_instr[0], dec_instr[1], dec_slot_vld, fetch_pc,
                                  2*k, 2*k, 2*k+1, 2*k+2);
            end
            step();
        end
        // Asynchronous reset mid-stream, away from the clock edge.
        #2 reset = 1'b1;
        #1;
        n_vec++; if (dec_valid !== 1'b0 || read_enable !== 1'b1 || fetch_pc !== 8'd0) begin
            n_err++; $display("FAIL midstream_reset: got v=%b re=%b fpc=%0d want 0/1/0", dec_valid, read_enable, fetch_pc);
        end
        step();
        reset = 1'b0;
        repeat (3) step();
        n_vec++; if (dec_valid !== 1'b0 || fetch_pc !== 8'd0 || read_enable !== 1'b1) begin
            n_err++; $display("FAIL post_reset_idle: got v=%b fpc=%0d re=%b want 0/0/1", dec_valid, fetch_pc, read_enable);
        end
    endtask

    task automatic test_backpressure();
        dec_ready = 1'b0; ilb_loaded = 1'b1;
        step();
        ilb_loaded = 1'b0;
        repeat (6) step();
        n_vec++; if (fetch_pc !== 8'd8) begin n_err++; $display("FAIL bp_frozen_a: got fpc=%0d want 8", fetch_pc); end
        step(); step();
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'd0 || fetch_pc !== 8'd8) begin
            n_err++; $display("FAIL bp_hold: got v=%b pc=%0d fpc=%0d want 1/0/8", dec_valid, dec_pc, fetch_pc);
        end
        dec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'(2*k) || dec_instr[1] !== 32'(2*k+1)) begin
                n_err++; $display("FAIL bp_drain%0d: got v=%b pc=%0d i1=%0d want 1/%0d/%0d",
                                  k, dec_valid, dec_pc, dec_instr[1], 2*k, 2*k+1);
            end
            step();
        end
    endtask

    task automatic test_odd_redirect();
        redirect_vld = 1'b1; redirect_pc = 8'd13;
        step();
        redirect_vld = 1'b0;
        n_vec++; if (dec_valid !== 1'b0 || fetch_pc !== 8'd12) begin
            n_err++; $display("FAIL odd_flush: got v=%b fpc=%0d want 0/12", dec_valid, fetch_pc);
        end
        step();
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'd12 || dec_slot_vld !== 2'b10 ||
                     dec_instr[0] !== C_NOP || dec_instr[1] !== 32'd13) begin
            n_err++; $display("FAIL odd_padded: got v=%b pc=%0d sv=%b i0=%h i1=%0d want 1/12/10/%h/13",
                              dec_valid, dec_pc, dec_slot_vld, dec_instr[0], dec_instr[1], C_NOP);
        end
        step();
        n_vec++; if (dec_pc !== 8'd14 || dec_slot_vld !== 2'b11 || dec_instr[0] !== 32'd14 || dec_instr[1] !== 32'd15) begin
            n_err++; $display("FAIL odd_next: got pc=%0d sv=%b i0=%0d i1=%0d want 14/11/14/15",
                              dec_pc, dec_slot_vld, dec_instr[0], dec_instr[1]);
        end
    endtask

    task automatic test_redirect_full();
        dec_ready = 1'b0;
        repeat (6) step();
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'd14 || fetch_pc !== 8'd22) begin
            n_err++; $display("FAIL full_hold: got v=%b pc=%0d fpc=%0d want 1/14/22", dec_valid, dec_pc, fetch_pc);
        end
        dec_ready = 1'b1; redirect_vld = 1'b1; redirect_pc = 8'd100;
        step();
        redirect_vld = 1'b0;
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL full_flush: got v=%b want 0", dec_valid); end
        step();
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'd100 || dec_slot_vld !== 2'b11 ||
                     dec_instr[0] !== 32'd100 || dec_instr[1] !== 32'd101) begin
            n_err++; $display("FAIL full_target: got v=%b pc=%0d sv=%b i0=%0d i1=%0d want 1/100/11/100/101",
                              dec_valid, dec_pc, dec_slot_vld, dec_instr[0], dec_instr[1]);
        end
    endtask

    task automatic test_end_of_buffer();
        redirect_vld = 1'b1; redirect_pc = 8'd250;
        step();
        redirect_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'(250 + 2*k)) begin
                n_err++; $display("FAIL eob_grp%0d: got v=%b pc=%0d want 1/%0d", k, dec_valid, dec_pc, 250 + 2*k);
            end
        end
        n_vec++; if (read_enable !== 1'b1 || fetch_pc !== 8'd0) begin
            n_err++; $display("FAIL eob_refill: got re=%b fpc=%0d want 1/0", read_enable, fetch_pc);
        end
        step(); step();
        n_vec++; if (dec_valid !== 1'b0 || read_enable !== 1'b1) begin
            n_err++; $display("FAIL eob_drained: got v=%b re=%b want 0/1", dec_valid, read_enable);
        end
        ilb_loaded = 1'b1;
        step();
        ilb_loaded = 1'b0;
        n_vec++; if (read_enable !== 1'b0) begin n_err++; $display("FAIL eob_reload_re: got %b want 0", read_enable); end
        step();
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'd0 || dec_instr[0] !== 32'd0 || dec_instr[1] !== 32'd1) begin
            n_err++; $display("FAIL eob_wrap: got v=%b pc=%0d i0=%0d i1=%0d want 1/0/0/1",
                              dec_valid, dec_pc, dec_instr[0], dec_instr[1]);
        end
        // Redirect straight onto the last group: one padded push, then refill.
        redirect_vld = 1'b1; redirect_pc = 8'd255;
        step();
        redirect_vld = 1'b0;
        step();
        n_vec++; if (dec_pc !== 8'd254 || dec_slot_vld !== 2'b10 || dec_instr[0] !== C_NOP ||
                     dec_instr[1] !== 32'd255 || read_enable !== 1'b1 || fetch_pc !== 8'd0) begin
            n_err++; $display("FAIL last_grp: got pc=%0d sv=%b i0=%h i1=%0d re=%b fpc=%0d want 254/10/%h/255/1/0",
                              dec_pc, dec_slot_vld, dec_instr[0], dec_instr[1], read_enable, fetch_pc, C_NOP);
        end
        redirect_vld = 1'b1; redirect_pc = 8'd40;
        step();
        redirect_vld = 1'b0;
        n_vec++; if (read_enable !== 1'b0 || fetch_pc !== 8'd40 || dec_valid !== 1'b0) begin
            n_err++; $display("FAIL refill_redir: got re=%b fpc=%0d v=%b want 0/40/0", read_enable, fetch_pc, dec_valid);
        end
        step();
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 8'd40 || dec_instr[0] !== 32'd40) begin
            n_err++; $display("FAIL refill_resume: got v=%b pc=%0d i0=%0d want 1/40/40", dec_valid, dec_pc, dec_instr[0]);
        end
    endtask

    initial begin
        reset        = 1'b1;
        ilb_loaded   = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = 8'd0;
        dec_ready    = 1'b0;
        for (int i = 0; i < 256; i++) cache[i] = 32'(i);
        step();
        step();
        reset = 1'b0;

        test_reset();
        test_redirect_in_load();
        test_streaming();
        test_backpressure();
        test_odd_redirect();
        test_redirect_full();
        test_end_of_buffer();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
